// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer for a 5-stage pipeline.
// Merges the load-use hazard, the taken branch and the data-memory handshake
// into per-register enables and flushes. A memory wait that lasts too long
// parks the pipeline in a sticky error state until reset. It also counts
// stall cycles and flush cycles.
module pipeline_stall_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_use,
    input  logic             br_taken,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exmem_en,
    output logic             memwb_flush,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_t;

    localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

    state_t     state_reg, state_next;
    logic [7:0] wcnt_reg, wcnt_next;
    logic       mem_stall;

    // Control values before reset gating is applied.
    logic pc_en_c, ifid_en_c, ifid_flush_c, idex_en_c, idex_flush_c, exmem_en_c, memwb_flush_c;

    assign mem_stall = dmem_req & ~dmem_ready;

    // State and wait-counter register. An asynchronous reset returns to RUN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= RUN;
            wcnt_reg  <= 8'd0;
        end else begin
            state_reg <= state_next;
            wcnt_reg  <= wcnt_next;
        end
    end

    // Next state and control values. A memory stall outranks a branch, and a branch outranks a load-use hazard.
    always_comb begin
        state_next    = state_reg;
        wcnt_next     = wcnt_reg;
        pc_en_c       = 1'b1;
        ifid_en_c     = 1'b1;
        ifid_flush_c  = 1'b0;
        idex_en_c     = 1'b1;
        idex_flush_c  = 1'b0;
        exmem_en_c    = 1'b1;
        memwb_flush_c = 1'b0;
        if (state_reg == ERR) begin
            pc_en_c       = 1'b0;
            ifid_en_c     = 1'b0;
            idex_en_c     = 1'b0;
            exmem_en_c    = 1'b0;
            memwb_flush_c = 1'b1;
        end else if (mem_stall) begin
            // Freeze every stage up to EX/MEM and send a bubble into writeback.
            pc_en_c       = 1'b0;
            ifid_en_c     = 1'b0;
            idex_en_c     = 1'b0;
            exmem_en_c    = 1'b0;
            memwb_flush_c = 1'b1;
            if (state_reg == RUN) begin
                state_next = MEM_WAIT;
                wcnt_next  = 8'd1;
            end else begin
                wcnt_next = wcnt_reg + 8'd1;
                if (wcnt_reg + 8'd1 == TIMEOUT) begin
                    state_next = ERR;
                end
            end
        end else begin
            state_next = RUN;
            wcnt_next  = 8'd0;
            if (br_taken) begin
                // Squash the wrong-path instructions in IF/ID and ID/EX.
                ifid_flush_c = 1'b1;
                idex_flush_c = 1'b1;
            end else if (load_use) begin
                // Hold fetch and decode for one cycle and insert a bubble into EX.
                pc_en_c      = 1'b0;
                ifid_en_c    = 1'b0;
                idex_flush_c = 1'b1;
            end
        end
    end

    // While in reset, hold every register and load bubbles.
    always_comb begin
        pc_en       = pc_en_c & ~rst;
        ifid_en     = ifid_en_c & ~rst;
        ifid_flush  = ifid_flush_c | rst;
        idex_en     = idex_en_c & ~rst;
        idex_flush  = idex_flush_c | rst;
        exmem_en    = exmem_en_c & ~rst;
        memwb_flush = memwb_flush_c | rst;
    end

    assign mem_err = (state_reg == ERR);

    // Performance counters. They wrap naturally and are not saturated.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!pc_en_c) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (ifid_flush_c) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed vector bench for pipeline_stall_ctrl.
// Output bit order used throughout this bench:
// {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_flush, mem_err}
module tb_pipeline_stall_ctrl;

    localparam int MEM_TIMEOUT = 16;
    localparam int CNT_W       = 32;

    localparam logic [7:0] O_RUN   = 8'b1101_0100;
    localparam logic [7:0] O_LU    = 8'b0001_1100;
    localparam logic [7:0] O_BR    = 8'b1111_1100;
    localparam logic [7:0] O_STALL = 8'b0000_0010;
    localparam logic [7:0] O_ERR   = 8'b0000_0011;
    localparam logic [7:0] O_RST   = 8'b0010_1010;

    logic clk = 1'b0;
    logic rst, load_use, br_taken, dmem_req, dmem_ready;
    logic pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_flush, mem_err;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [3:0] in;      // {load_use, br_taken, dmem_req, dmem_ready}
        logic [7:0] out;
        int         stall;   // counter values seen before this cycle's edge
        int         flush;
    } vec_t;

    vec_t vecs[$];

    pipeline_stall_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .load_use(load_use), .br_taken(br_taken),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready), .pc_en(pc_en),
        .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_en(idex_en),
        .idex_flush(idex_flush), .exmem_en(exmem_en), .memwb_flush(memwb_flush),
        .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] outs();
        return {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_flush, mem_err};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic add(input logic [3:0] in, input logic [7:0] out, input int s, input int f);
        vec_t v;
        v.in = in; v.out = out; v.stall = s; v.flush = f;
        vecs.push_back(v);
    endtask

    // Drive inputs, check at the falling edge, then advance one clock.
    task automatic cyc(input string name, input logic [3:0] in, input logic [7:0] exp_out,
                       input int s, input int f);
        {load_use, br_taken, dmem_req, dmem_ready} = in;
        @(negedge clk);
        chk({name, " outs"}, 32'(outs()), 32'(exp_out));
        chk({name, " stall_cnt"}, stall_cnt, s);
        chk({name, " flush_cnt"}, flush_cnt, f);
        $display("%s in=%b outs=%b stall=%0d flush=%0d", name, in, outs(), stall_cnt, flush_cnt);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        {load_use, br_taken, dmem_req, dmem_ready} = 4'b0000;

        // Idle, a single load-use bubble, then a branch that outranks load-use.
        for (int i = 0; i < 10; i++) add(4'b0000, O_RUN, 0, 0);
        add(4'b1000, O_LU, 0, 0);
        add(4'b0000, O_RUN, 1, 0);
        add(4'b1100, O_BR, 1, 0);
        add(4'b0000, O_RUN, 1, 1);
        // A three-cycle memory stall followed by completion.
        add(4'b0010, O_STALL, 1, 1);
        add(4'b0010, O_STALL, 2, 1);
        add(4'b0010, O_STALL, 3, 1);
        add(4'b0011, O_RUN, 4, 1);
        add(4'b0000, O_RUN, 4, 1);
        // A branch held across a stall takes effect only on the release cycle.
        add(4'b0110, O_STALL, 4, 1);
        add(4'b0110, O_STALL, 5, 1);
        add(4'b0111, O_BR, 6, 1);
        add(4'b0000, O_RUN, 6, 2);
        // A load-use held across a stall also takes effect on the release cycle.
        add(4'b1010, O_STALL, 6, 2);
        add(4'b1011, O_LU, 7, 2);
        add(4'b0000, O_RUN, 8, 2);
        // A memory access that completes at once does not stall.
        add(4'b0011, O_RUN, 8, 2);
        add(4'b0000, O_RUN, 8, 2);

        // Reset state
        @(negedge clk);
        chk("reset outs", 32'(outs()), 32'(O_RST));
        chk("reset stall_cnt", stall_cnt, 0);
        chk("reset flush_cnt", flush_cnt, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        foreach (vecs[i]) begin
            cyc($sformatf("vec%0d", i), vecs[i].in, vecs[i].out, vecs[i].stall, vecs[i].flush);
        end

        // One cycle short of the timeout: the release still returns to RUN.
        for (int k = 0; k < MEM_TIMEOUT - 1; k++)
            cyc($sformatf("near%0d", k), 4'b0010, O_STALL, 8 + k, 2);
        cyc("near_release", 4'b0011, O_RUN, 8 + MEM_TIMEOUT - 1, 2);
        cyc("near_idle", 4'b0000, O_RUN, 8 + MEM_TIMEOUT - 1, 2);

        // A full timeout enters the sticky error state.
        for (int k = 0; k < MEM_TIMEOUT; k++)
            cyc($sformatf("to%0d", k), 4'b0010, O_STALL, 23 + k, 2);
        cyc("err0", 4'b0011, O_ERR, 23 + MEM_TIMEOUT, 2);
        cyc("err1", 4'b0000, O_ERR, 24 + MEM_TIMEOUT, 2);
        cyc("err2", 4'b0100, O_ERR, 25 + MEM_TIMEOUT, 2);

        // An asynchronous reset pulse between clock edges clears everything.
        {load_use, br_taken, dmem_req, dmem_ready} = 4'b0000;
        #2;
        rst = 1'b1;
        #1;
        chk("async rst outs", 32'(outs()), 32'(O_RST));
        chk("async rst stall_cnt", stall_cnt, 0);
        chk("async rst flush_cnt", flush_cnt, 0);
        $display("async_rst outs=%b stall=%0d flush=%0d", outs(), stall_cnt, flush_cnt);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc("post_rst0", 4'b0000, O_RUN, 0, 0);
        cyc("post_rst1", 4'b1000, O_LU, 0, 0);
        cyc("post_rst2", 4'b0000, O_RUN, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
